// File: rtl/uart_echo_responder_if.sv
// Handshake bundle between the echo responder and the UART rx/tx pair.
// master: the echo responder. slave: the rx_module/tx_module side.
interface uart_echo_responder_if #(
   parameter int FIFO_AW = 2
);
   logic                 Rx_Done_Sig;
   logic [7:0]           Rx_Data;
   logic                 Rx_En_Sig;
   logic                 Tx_Done_Sig;
   logic                 Tx_En_Sig;
   logic [7:0]           Tx_Data;
   logic [FIFO_AW:0]     Fifo_Count;
   logic                 Overflow_Sig;

   modport master (
      input  Rx_Done_Sig, Rx_Data, Tx_Done_Sig,
      output Rx_En_Sig, Tx_En_Sig, Tx_Data, Fifo_Count, Overflow_Sig
   );

   modport slave (
      output Rx_Done_Sig, Rx_Data, Tx_Done_Sig,
      input  Rx_En_Sig, Tx_En_Sig, Tx_Data, Fifo_Count, Overflow_Sig
   );
endinterface

// File: rtl/uart_echo_responder.sv
// uart_echo_responder: buffers bytes from rx_module in a small circular FIFO
// and replays them in order to tx_module using the hold-until-done handshake.
// Optional macro ECHO_UPPERCASE_EN: lowercase ASCII is converted to uppercase
// as each byte is loaded into Tx_Data (FIFO contents are never altered).
module uart_echo_responder #(
   parameter int FIFO_AW = 2
) (
   input  logic                   CLK,
   input  logic                   RST_n,
   uart_echo_responder_if.master  bus
);
   localparam int               DEPTH     = 2 ** FIFO_AW;
   localparam logic [FIFO_AW:0] DEPTH_CNT = (FIFO_AW + 1)'(DEPTH);

   typedef enum logic [1:0] {IDLE, SEND, GAP} state_t;

   state_t               state_reg, state_next;
   logic [7:0]           mem [DEPTH];
   logic [FIFO_AW-1:0]   rd_ptr_reg, wr_ptr_reg;
   logic [FIFO_AW:0]     count_reg;
   logic                 tx_en_reg, tx_en_next;
   logic [7:0]           tx_data_reg, tx_data_next;
   logic                 overflow_reg;
   logic                 full, push, pop;

`ifdef ECHO_UPPERCASE_EN
   function automatic logic [7:0] echo_xform(input logic [7:0] b);
      if (b >= 8'h61 && b <= 8'h7A)
         return b - 8'h20;
      return b;
   endfunction
`else
   function automatic logic [7:0] echo_xform(input logic [7:0] b);
      return b;
   endfunction
`endif

   assign full = (count_reg == DEPTH_CNT);
   // A pop in the same cycle frees the slot, so a push at full is still accepted.
   assign push = bus.Rx_Done_Sig && (!full || pop);

   assign bus.Rx_En_Sig    = !full;
   assign bus.Tx_En_Sig    = tx_en_reg;
   assign bus.Tx_Data      = tx_data_reg;
   assign bus.Fifo_Count   = count_reg;
   assign bus.Overflow_Sig = overflow_reg;

   // FIFO storage write; left unreset so it maps onto plain RAM.
   always_ff @(posedge CLK) begin
      if (push)
         mem[wr_ptr_reg] <= bus.Rx_Data;
   end

   // FIFO pointers, occupancy count and sticky overflow flag.
   always_ff @(posedge CLK) begin
      if (!RST_n) begin
         rd_ptr_reg   <= '0;
         wr_ptr_reg   <= '0;
         count_reg    <= '0;
         overflow_reg <= 1'b0;
      end else begin
         if (push)
            wr_ptr_reg <= wr_ptr_reg + FIFO_AW'(1);
         if (pop)
            rd_ptr_reg <= rd_ptr_reg + FIFO_AW'(1);
         case ({push, pop})
            2'b10:   count_reg <= count_reg + (FIFO_AW + 1)'(1);
            2'b01:   count_reg <= count_reg - (FIFO_AW + 1)'(1);
            default: count_reg <= count_reg;
         endcase
         if (bus.Rx_Done_Sig && full && !pop)
            overflow_reg <= 1'b1;
      end
   end

   // Transmit FSM state and registered handshake outputs.
   always_ff @(posedge CLK) begin
      if (!RST_n) begin
         state_reg   <= IDLE;
         tx_en_reg   <= 1'b0;
         tx_data_reg <= 8'h00;
      end else begin
         state_reg   <= state_next;
         tx_en_reg   <= tx_en_next;
         tx_data_reg <= tx_data_next;
      end
   end

   // Next-state logic: load the FIFO head in IDLE, hold through SEND, one GAP cycle.
   always_comb begin
      state_next   = state_reg;
      tx_en_next   = tx_en_reg;
      tx_data_next = tx_data_reg;
      pop          = 1'b0;
      case (state_reg)
         IDLE: begin
            if (count_reg != '0) begin
               pop          = 1'b1;
               tx_data_next = echo_xform(mem[rd_ptr_reg]);
               tx_en_next   = 1'b1;
               state_next   = SEND;
            end
         end
         SEND: begin
            if (bus.Tx_Done_Sig) begin
               tx_en_next = 1'b0;
               state_next = GAP;
            end
         end
         GAP: begin
            tx_en_next = 1'b0;
            state_next = IDLE;
         end
         default: begin
            tx_en_next = 1'b0;
            state_next = IDLE;
         end
      endcase
   end
endmodule

// File: tb/tb_uart_echo_responder.sv
// Directed bench for uart_echo_responder with an in-order byte scoreboard.
// Inputs are driven and outputs sampled on the falling edge of CLK.
module tb_uart_echo_responder;
   localparam int FIFO_AW = 2;

   logic       CLK = 1'b0;
   logic       RST_n = 1'b0;
   int         checks = 0;
   int         errors = 0;
   logic [7:0] sb [$];

   uart_echo_responder_if #(.FIFO_AW(FIFO_AW)) bus ();

   uart_echo_responder #(.FIFO_AW(FIFO_AW)) dut (
      .CLK   (CLK),
      .RST_n (RST_n),
      .bus   (bus)
   );

   always #5 CLK = ~CLK;

   // Reference echo transform for the scoreboard.
   function automatic logic [7:0] model_xform(input logic [7:0] b);
`ifdef ECHO_UPPERCASE_EN
      if (b >= 8'h61 && b <= 8'h7A)
         return b - 8'h20;
`endif
      return b;
   endfunction

   task automatic step();
      @(negedge CLK);
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic do_reset();
      RST_n = 1'b0;
      step();
      step();
      RST_n = 1'b1;
      sb.delete();
   endtask

   // One-cycle Rx_Done_Sig pulse; accepted bytes go to the scoreboard.
   task automatic push(input logic [7:0] b, input bit accept);
      bus.Rx_Done_Sig = 1'b1;
      bus.Rx_Data     = b;
      if (accept)
         sb.push_back(model_xform(b));
      step();
      bus.Rx_Done_Sig = 1'b0;
      bus.Rx_Data     = 8'h00;
      $display("rx push %02h accept=%0d count=%0d", b, accept, bus.Fifo_Count);
   endtask

   // Wait (bounded) for a transmit request and compare against the scoreboard head.
   task automatic wait_tx(input string tag);
      logic [7:0] exp;
      int n = 0;
      while (bus.Tx_En_Sig !== 1'b1 && n < 50) begin
         step();
         n++;
      end
      if (bus.Tx_En_Sig !== 1'b1) begin
         check({tag, "_timeout"}, 32'(bus.Tx_En_Sig), 32'd1);
         return;
      end
      if (sb.size() == 0) begin
         check({tag, "_unexpected_tx"}, 32'(bus.Tx_Data), 32'hFFFF_FFFF);
         return;
      end
      exp = sb.pop_front();
      check(tag, 32'(bus.Tx_Data), 32'(exp));
      $display("tx data %02h expected %02h", bus.Tx_Data, exp);
   endtask

   // Complete the current send and confirm the two-cycle low gap.
   task automatic finish_tx();
      bus.Tx_Done_Sig = 1'b1;
      step();
      bus.Tx_Done_Sig = 1'b0;
      check("gap_low", 32'(bus.Tx_En_Sig), 32'd0);
      step();
      check("idle_low", 32'(bus.Tx_En_Sig), 32'd0);
   endtask

   task automatic drain(input int n, input string tag);
      for (int i = 0; i < n; i++) begin
         wait_tx(tag);
         finish_tx();
      end
   endtask

   initial begin
      logic seen;
      bus.Rx_Done_Sig = 1'b0;
      bus.Rx_Data     = 8'h00;
      bus.Tx_Done_Sig = 1'b0;

      // Reset values
      step();
      check("rst_tx_en", 32'(bus.Tx_En_Sig), 32'd0);
      check("rst_tx_data", 32'(bus.Tx_Data), 32'h00);
      check("rst_count", 32'(bus.Fifo_Count), 32'd0);
      check("rst_ovf", 32'(bus.Overflow_Sig), 32'd0);
      check("rst_rx_en", 32'(bus.Rx_En_Sig), 32'd1);
      do_reset();

      // Single byte latency and hold
      push(8'h2E, 1'b1);
      check("single_count1", 32'(bus.Fifo_Count), 32'd1);
      check("single_tx_en_early", 32'(bus.Tx_En_Sig), 32'd0);
      step();
      check("single_tx_en", 32'(bus.Tx_En_Sig), 32'd1);
      check("single_count0", 32'(bus.Fifo_Count), 32'd0);
      wait_tx("single_data");
      step(); step(); step();
      check("single_hold_en", 32'(bus.Tx_En_Sig), 32'd1);
      check("single_hold_data", 32'(bus.Tx_Data), 32'h2E);
      finish_tx();
      check("single_end_count", 32'(bus.Fifo_Count), 32'd0);

      // Tx_Done_Sig outside SEND is ignored
      bus.Tx_Done_Sig = 1'b1;
      step();
      bus.Tx_Done_Sig = 1'b0;
      push(8'h19, 1'b1);
      step(); step(); step();
      check("stray_done_hold", 32'(bus.Tx_En_Sig), 32'd1);
      drain(1, "stray_done_data");

      // Burst ordering
      push(8'h2E, 1'b1);
      push(8'h3F, 1'b1);
      push(8'hAA, 1'b1);
      check("burst_peak", 32'(bus.Fifo_Count), 32'd2);
      drain(3, "burst_data");
      check("burst_ovf", 32'(bus.Overflow_Sig), 32'd0);

      // Full / overflow
      do_reset();
      for (int i = 1; i <= 5; i++)
         push(8'(i), 1'b1);
      check("full_count", 32'(bus.Fifo_Count), 32'd4);
      check("full_rx_en", 32'(bus.Rx_En_Sig), 32'd0);
      check("full_ovf_before", 32'(bus.Overflow_Sig), 32'd0);
      push(8'h06, 1'b0);
      check("ovf_set", 32'(bus.Overflow_Sig), 32'd1);
      check("ovf_count", 32'(bus.Fifo_Count), 32'd4);
      drain(5, "ovf_data");
      step(); step(); step();
      check("ovf_no_extra", 32'(bus.Tx_En_Sig), 32'd0);
      check("ovf_sticky", 32'(bus.Overflow_Sig), 32'd1);

      // Push and pop at full
      do_reset();
      for (int i = 1; i <= 5; i++)
         push(8'(i), 1'b1);
      wait_tx("pp_first");
      finish_tx();
      push(8'h55, 1'b1);
      check("pp_count", 32'(bus.Fifo_Count), 32'd4);
      check("pp_ovf", 32'(bus.Overflow_Sig), 32'd0);
      check("pp_tx_en", 32'(bus.Tx_En_Sig), 32'd1);
      drain(5, "pp_data");
      check("pp_end_count", 32'(bus.Fifo_Count), 32'd0);

      // Reset mid-operation
      do_reset();
      push(8'h11, 1'b1);
      push(8'h22, 1'b1);
      push(8'h33, 1'b1);
      push(8'h44, 1'b1);
      check("mid_count", 32'(bus.Fifo_Count), 32'd3);
      wait_tx("mid_first");
      RST_n = 1'b0;
      step();
      RST_n = 1'b1;
      sb.delete();
      check("mid_rst_tx_en", 32'(bus.Tx_En_Sig), 32'd0);
      check("mid_rst_count", 32'(bus.Fifo_Count), 32'd0);
      check("mid_rst_ovf", 32'(bus.Overflow_Sig), 32'd0);
      seen = 1'b0;
      for (int i = 0; i < 10; i++) begin
         step();
         seen = seen | bus.Tx_En_Sig;
      end
      check("mid_no_stale", 32'(seen), 32'd0);
      push(8'h7E, 1'b1);
      drain(1, "mid_after");

      // Uppercase option
      push(8'h61, 1'b1);
      push(8'h7A, 1'b1);
      push(8'h7B, 1'b1);
      drain(3, "case_data");

      check("sb_empty", 32'(sb.size()), 32'd0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
